// File: rtl/serial_magnitude_comparator_if.sv
// ============================================================================
// Module : serial_magnitude_comparator_if
// Brief  : Operand/result handshake bundle for serial_magnitude_comparator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface serial_magnitude_comparator_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic             gt;
  logic             eq;
  logic             lt;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, gt, eq, lt
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, gt, eq, lt
  );
endinterface

`default_nettype wire

// File: rtl/serial_magnitude_comparator.sv
// ============================================================================
// Module : serial_magnitude_comparator
// Brief  : Multi-cycle MSB-first magnitude compare, DIGIT bits per clock,
//          early exit on first differing digit, signed/unsigned per request.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  wire logic                      clk,
  input  wire logic                      rst_n,
  input  wire logic                      flush,
  serial_magnitude_comparator_if.slave   bus
);

  localparam int c_NDIG = WIDTH / DIGIT;
  localparam int c_IDXW = (c_NDIG > 1) ? $clog2(c_NDIG) : 1;
  localparam logic [c_IDXW-1:0] c_IDX_LAST = c_IDXW'(c_NDIG - 1);
  localparam logic [WIDTH-1:0]  c_MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  generate
    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_magnitude_comparator: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [c_IDXW-1:0] r_idx;
  logic              r_gt;
  logic              r_eq;
  logic              r_lt;

  logic [DIGIT-1:0]  w_da;
  logic [DIGIT-1:0]  w_db;

  generate
    if (c_NDIG == 1) begin : g_single_digit
      assign w_da = r_a;
      assign w_db = r_b;
    end else begin : g_multi_digit
      logic [c_NDIG-1:0][DIGIT-1:0] w_adig;
      logic [c_NDIG-1:0][DIGIT-1:0] w_bdig;
      assign w_adig = r_a;
      assign w_bdig = r_b;
      assign w_da   = w_adig[r_idx];
      assign w_db   = w_bdig[r_idx];
    end
  endgenerate

  // Flipping the sign bit at capture turns a signed compare into an unsigned one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_gt    <= 1'b0;
      r_eq    <= 1'b0;
      r_lt    <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_gt    <= 1'b0;
      r_eq    <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.a ^ (bus.is_signed ? c_MSB_MASK : '0);
            r_b     <= bus.b ^ (bus.is_signed ? c_MSB_MASK : '0);
            r_idx   <= c_IDX_LAST;
            r_gt    <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_da != w_db) begin
            r_gt    <= (w_da > w_db);
            r_lt    <= (w_da < w_db);
            r_eq    <= 1'b0;
            r_state <= S_DONE;
          end else if (r_idx == '0) begin
            r_eq    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx - 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_gt    <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.gt        = r_gt;
  assign bus.eq        = r_eq;
  assign bus.lt        = r_lt;

endmodule

`default_nettype wire

// File: tb/tb_serial_magnitude_comparator.sv
// ============================================================================
// Module : tb_serial_magnitude_comparator
// Brief  : Drives four comparator configurations in lockstep against a
//          plain-arithmetic reference of compare result and digit latency.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_magnitude_comparator;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        is_signed;
  logic        out_ready;
  logic [15:0] a16, b16;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;

  int n_checks = 0;
  int n_errors = 0;

  localparam int c_NDUT = 4;
  int cfg_w [c_NDUT] = '{16, 4, 4, 8};
  int cfg_d [c_NDUT] = '{4, 1, 2, 8};

  serial_magnitude_comparator_if #(.WIDTH(16)) if16 ();
  serial_magnitude_comparator_if #(.WIDTH(4))  if41 ();
  serial_magnitude_comparator_if #(.WIDTH(4))  if42 ();
  serial_magnitude_comparator_if #(.WIDTH(8))  if88 ();

  assign if16.in_valid = in_valid;  assign if16.is_signed = is_signed;
  assign if16.out_ready = out_ready; assign if16.a = a16; assign if16.b = b16;
  assign if41.in_valid = in_valid;  assign if41.is_signed = is_signed;
  assign if41.out_ready = out_ready; assign if41.a = a4;  assign if41.b = b4;
  assign if42.in_valid = in_valid;  assign if42.is_signed = is_signed;
  assign if42.out_ready = out_ready; assign if42.a = a4;  assign if42.b = b4;
  assign if88.in_valid = in_valid;  assign if88.is_signed = is_signed;
  assign if88.out_ready = out_ready; assign if88.a = a8;  assign if88.b = b8;

  serial_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(if16));
  serial_magnitude_comparator #(.WIDTH(4),  .DIGIT(1)) u_dut41 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(if41));
  serial_magnitude_comparator #(.WIDTH(4),  .DIGIT(2)) u_dut42 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(if42));
  serial_magnitude_comparator #(.WIDTH(8),  .DIGIT(8)) u_dut88 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(if88));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic dut_ov(input int k);
    case (k)
      0: return if16.out_valid;
      1: return if41.out_valid;
      2: return if42.out_valid;
      default: return if88.out_valid;
    endcase
  endfunction

  function automatic logic dut_ir(input int k);
    case (k)
      0: return if16.in_ready;
      1: return if41.in_ready;
      2: return if42.in_ready;
      default: return if88.in_ready;
    endcase
  endfunction

  function automatic logic [2:0] dut_res(input int k);
    case (k)
      0: return {if16.gt, if16.eq, if16.lt};
      1: return {if41.gt, if41.eq, if41.lt};
      2: return {if42.gt, if42.eq, if42.lt};
      default: return {if88.gt, if88.eq, if88.lt};
    endcase
  endfunction

  function automatic int op_a(input int k);
    case (k)
      0: return int'(a16);
      1, 2: return int'(a4);
      default: return int'(a8);
    endcase
  endfunction

  function automatic int op_b(input int k);
    case (k)
      0: return int'(b16);
      1, 2: return int'(b4);
      default: return int'(b8);
    endcase
  endfunction

  // Result as {gt,eq,lt} from integer compare; latency = digits read MSB-first up to the first difference.
  function automatic void ref_model(input int w, input int d, input int a, input int b,
                                    input bit sgn, output logic [2:0] res, output int lat);
    int va, vb, nd, dmask;
    va = a; vb = b;
    if (sgn && va >= (1 << (w - 1))) va = va - (1 << w);
    if (sgn && vb >= (1 << (w - 1))) vb = vb - (1 << w);
    res = (va > vb) ? 3'b100 : (va == vb) ? 3'b010 : 3'b001;
    nd = w / d;
    dmask = (1 << d) - 1;
    lat = nd;
    for (int i = nd - 1; i >= 0; i--) begin
      if (((a >> (i * d)) & dmask) != ((b >> (i * d)) & dmask)) begin
        lat = nd - i;
        break;
      end
    end
  endfunction

  task automatic randomize_ops();
    a16 = 16'($urandom); b16 = 16'($urandom);
    a8  = 8'($urandom);  b8  = 8'($urandom);
    a4  = 4'($urandom);  b4  = 4'($urandom);
  endtask

  // Entered at posedge+1 with all DUTs idle and operands already set.
  task automatic transact(input int hold);
    logic [2:0] eres [c_NDUT];
    int         elat [c_NDUT];
    int         olat [c_NDUT];
    bit         all_done;
    for (int k = 0; k < c_NDUT; k++) begin
      ref_model(cfg_w[k], cfg_d[k], op_a(k), op_b(k), is_signed, eres[k], elat[k]);
      olat[k] = 0;
      check($sformatf("in_ready_pre[%0d]", k), 32'(dut_ir(k)), 32'd1);
    end
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    randomize_ops();
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(posedge clk); #1;
      all_done = 1'b1;
      for (int k = 0; k < c_NDUT; k++) begin
        if (olat[k] == 0 && dut_ov(k)) olat[k] = cyc;
        if (olat[k] == 0) all_done = 1'b0;
      end
      if (all_done) break;
    end
    for (int k = 0; k < c_NDUT; k++) begin
      check($sformatf("result[%0d] s=%0d", k, is_signed), 32'(dut_res(k)), 32'(eres[k]));
      check($sformatf("latency[%0d]", k), 32'(olat[k]), 32'(elat[k]));
    end
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom);
      randomize_ops();
      @(posedge clk); #1;
      for (int k = 0; k < c_NDUT; k++) begin
        check($sformatf("hold_state[%0d]", k),
              {29'd0, dut_ov(k), dut_ir(k), 1'b0} | 32'(dut_res(k)) << 3,
              {29'd0, 1'b1, 1'b0, 1'b0} | 32'(eres[k]) << 3);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < c_NDUT; k++) begin
      check($sformatf("post_drain[%0d]", k),
            {28'd0, dut_ov(k), dut_ir(k), dut_res(k) == 3'b000, 1'b0},
            {28'd0, 1'b0, 1'b1, 1'b1, 1'b0});
    end
  endtask

  task automatic expect_no_valid(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < c_NDUT; k++) if (dut_ov(k)) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; is_signed = 1'b0; out_ready = 1'b0;
    a16 = '0; b16 = '0; a8 = '0; b8 = '0; a4 = '0; b4 = '0;
    #1;
    for (int k = 0; k < c_NDUT; k++)
      check($sformatf("reset_state[%0d]", k), {28'd0, dut_ov(k), dut_res(k)}, 32'd0);
    check("reset_in_ready", 32'(dut_ir(0)), 32'd1);
    #20;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed operand patterns on the 16/4 instance.
    a16 = 16'h8000; b16 = 16'h7FFF; is_signed = 1'b0; transact(0);
    a16 = 16'h8000; b16 = 16'h7FFF; is_signed = 1'b1; transact(0);
    a16 = 16'h1234; b16 = 16'h1234; is_signed = 1'b0; transact(0);
    a16 = 16'h1334; b16 = 16'h1234; is_signed = 1'b0; transact(0);
    a16 = 16'h1234; b16 = 16'h1235; is_signed = 1'b0; transact(0);

    // Long backpressure with toggling inputs.
    a16 = 16'hFFFE; b16 = 16'h0001; a8 = 8'h80; b8 = 8'h7F; is_signed = 1'b1; transact(5);

    // Async reset between edges during SCAN.
    a16 = 16'hFFFF; b16 = 16'hFFFF; a4 = 4'h0; b4 = 4'h0; is_signed = 1'b0;
    in_valid = 1'b1; @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    check("rst_scan_out", {28'd0, if16.out_valid, if16.gt, if16.eq, if16.lt}, 32'd0);
    check("rst_scan_ready", 32'(if16.in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Async reset between edges while holding a result.
    a16 = 16'h8000; b16 = 16'h7FFF; is_signed = 1'b0;
    in_valid = 1'b1; @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_done", {28'd0, if16.out_valid, if16.gt, if16.eq, if16.lt}, 32'b1100);
    #2; rst_n = 1'b0; #1;
    check("rst_done_out", {28'd0, if16.out_valid, if16.gt, if16.eq, if16.lt}, 32'd0);
    check("rst_done_ready", 32'(if16.in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Flush in the second SCAN cycle.
    a16 = 16'hFFFF; b16 = 16'hFFFF; a4 = 4'h5; b4 = 4'h5; a8 = 8'h11; b8 = 8'h11;
    in_valid = 1'b1; @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
    for (int k = 0; k < c_NDUT; k++)
      check($sformatf("flush_idle[%0d]", k), 32'(dut_ir(k)), 32'd1);
    expect_no_valid("flush_no_valid", 8);

    // Flush coincident with in_valid in IDLE must not accept.
    flush = 1'b1; in_valid = 1'b1; @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < c_NDUT; k++)
      check($sformatf("flush_noaccept[%0d]", k), 32'(dut_ir(k)), 32'd1);
    expect_no_valid("flush_accept_no_valid", 6);

    // Random mixed traffic.
    for (int t = 0; t < 40; t++) begin
      randomize_ops();
      if ($urandom_range(0, 3) == 0) b16 = a16;
      is_signed = 1'($urandom);
      transact(int'($urandom_range(0, 3)));
    end

    // Exhaustive 4-bit sweep in both modes.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 256; i++) begin
        randomize_ops();
        a4 = 4'(i >> 4);
        b4 = 4'(i);
        is_signed = 1'(s);
        transact(0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
Parametrised, multi-cycle magnitude comparator. It compares two WIDTH-bit operands most-significant digit first, DIGIT bits per clock, and stops early at the first differing digit. It supports unsigned and two's-complement signed compares, selected per transaction, and reports gt/eq/lt. It uses valid/ready handshakes on both the input and output sides. It is the sequential, width-scalable successor to the fixed 4-bit gate-level greater-than comparator, for use where a wide single-cycle compare would break timing.

Parameters:
WIDTH, 16, operand width in bits; must be >= 1.
DIGIT, 4, bits compared per cycle; 1 <= DIGIT <= WIDTH; WIDTH % DIGIT == 0 (elaboration-time assertion).
(Derived) NDIG = WIDTH/DIGIT. Index register width = max(1, $clog2(NDIG)).

Ports:
clk        input   1      system clock, rising edge
rst_n      input   1      asynchronous active-low reset
flush      input   1      synchronous abort; return to IDLE
in_valid   input   1      operands valid
in_ready   output  1      block can accept operands
a          input   WIDTH  operand A
b          input   WIDTH  operand B
is_signed  input   1      1 = two's-complement compare, 0 = unsigned
out_valid  output  1      result valid
out_ready  input   1      consumer accepts result
gt         output  1      A > B
eq         output  1      A == B
lt         output  1      A < B

Behaviour:
- Reset is asynchronous and active-low. On rst_n=0: state=IDLE; gt, eq, lt and out_valid=0 immediately; captured operands cleared. in_ready=1 while in IDLE, including during reset.
- States: IDLE, SCAN, DONE. in_ready = (state==IDLE). out_valid = (state==DONE). Both are decoded from registered state only, with no combinational path from inputs.
- IDLE:
  - Accept occurs when in_valid && in_ready && !flush.
  - On accept, capture a and b. Store MSB of each XORed with is_signed; this bias maps signed order onto unsigned order.
  - Set digit index = NDIG-1, clear gt/eq/lt, go to SCAN.
- SCAN: each cycle, compare captured digits [idx*DIGIT +: DIGIT] as unsigned values.
  - Digits differ: register gt/lt accordingly, eq=0, go to DONE.
  - Digits equal and idx==0: register eq=1, go to DONE.
  - Otherwise: idx decrements; stay in SCAN.
- Latency: out_valid rises k cycles after the accept edge, where k = number of digits examined (1..NDIG). Worst case is NDIG cycles (equal operands or difference in the last digit).
- DONE:
  - gt/eq/lt hold stable while out_valid=1 && out_ready=0.
  - On out_ready=1: go to IDLE next cycle and clear gt/eq/lt/out_valid.
  - Exactly one of gt/eq/lt is high whenever out_valid=1. All three are 0 otherwise.
- No overlap between transactions: in_valid is ignored outside IDLE. Back-to-back throughput is one result per (k+2) cycles minimum.
- flush: has priority over every other event in every state. Next state is IDLE, outputs are cleared, and no out_valid is produced for an aborted transaction. flush with in_valid in IDLE causes no accept.
- rst_n deasserted mid-SCAN or DONE aborts the transaction; the result is lost.
- Operands are captured, so a and b may change after the accept edge without effect.
- DIGIT==WIDTH degenerates to a one-cycle SCAN. NDIG==1 uses a 1-bit index held at 0.

Test Plan:
1. WIDTH=16, DIGIT=4, is_signed=0, a=0x8000, b=0x7FFF -> gt=1, eq=lt=0, out_valid high 1 cycle after accept.
2. Same operands with is_signed=1 -> lt=1 (-32768 < 32767), out_valid 1 cycle after accept.
3. a=b=0x1234, unsigned -> eq=1 after 4 cycles. a=0x1334, b=0x1234 -> gt=1 after 2 cycles. a=0x1234, b=0x1235 -> lt=1 after 4 cycles.
4. Backpressure: hold out_ready=0 for 5 cycles while toggling in_valid and the operands -> in_ready=0, gt/eq/lt/out_valid stable. Then out_ready=1 -> IDLE and in_ready=1 the next cycle, outputs cleared.
5. Reset and flush aborts:
   - Assert rst_n=0 between edges mid-SCAN -> outputs 0 without a clock edge, in_ready=1.
   - Assert flush in the 2nd SCAN cycle of a=b=0xFFFF -> IDLE next cycle, out_valid never asserts.
   - flush together with in_valid in IDLE -> no accept.
6. Exhaustive sweep with WIDTH=4, DIGIT=1 and WIDTH=4, DIGIT=2, both modes, all 256 pairs -> gt/eq/lt match $signed/$unsigned reference compares; one-hot result; latency within 1..NDIG.
